// File: rtl/output_buffer_pkg.sv
// Shared types and helpers for the output-buffer write arbiter.
package output_buffer_pkg;

  // Arbiter pass state: wait for start, run the pass, one-cycle completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Width needed to hold a requester index (at least one bit).
  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible index at or above the
// pointer, wrapping around, reported as one-hot plus binary index.
module rr_priority_picker
  import output_buffer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && i_elig[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_valid                                  = 1'b1;
        o_grant[(int'(i_ptr) + k) % NUM_REQ]     = 1'b1;
        o_idx                                    = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/output_buffer_write_arbiter.sv
// Round-robin arbiter sharing one output-buffer FIFO write port between
// several result producers, with a fixed per-requester quota per pass.
//
// Handshake: a requester's result is consumed in the cycle where req[i]=1 and
// grant[i]=1; the FIFO takes din at that same rising edge (wen=1 only when
// ready=1). Any asserted req without grant sees stall[i]=1 and must hold.
module output_buffer_write_arbiter
  import output_buffer_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_REQ         = 4,
  parameter int RESULTS_PER_REQ = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            stall,
  output logic                          wen,
  output logic [DATA_WIDTH-1:0]         din,
  output logic                          par_done,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(RESULTS_PER_REQ + 1);
  localparam logic [CNT_W-1:0] QUOTA = CNT_W'(RESULTS_PER_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt [NUM_REQ];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_all_met_next;
  logic               w_start_pass;

  assign w_start_pass = (r_state == ST_IDLE) && start;

  // Eligible: running, FIFO has room, result present and quota not yet met.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = (r_state == ST_RUN) && ready && req[i] && (r_cnt[i] < QUOTA);
    end
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Quotas as they will stand after this edge, so DONE follows the last write.
  always_comb begin
    w_all_met_next = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!((r_cnt[i] == QUOTA) || (w_grant[i] && (r_cnt[i] == QUOTA - CNT_W'(1))))) begin
        w_all_met_next = 1'b0;
      end
    end
  end

  // Pass sequencing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_all_met_next) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Per-requester write counters and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else if (w_start_pass) begin
      r_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else if (w_valid) begin
      r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + IDX_W'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Write data mux: granted slice, zero when nothing is granted.
  always_comb begin
    din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant     = w_grant;
  assign wen       = w_valid;
  assign stall     = req & ~w_grant;
  assign par_done  = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
